// File: rtl/shift_unit_mc.sv
// ============================================================================
// Module   : shift_unit_mc
// Purpose  : Multi-cycle SLL/SRL/SRA shifter that moves at most STEP bit
//            positions per clock, with valid/ready request and response.
//            ROL/ROR are decoded only when SHIFT_UNIT_ROT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_unit_mc #(
    parameter int XLEN = 32,
    parameter int STEP = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [3:0]      funct_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] res_o,
    output logic            busy_o
);

    localparam int SW = $clog2(XLEN);

    localparam logic [3:0]  c_sll    = 4'b0001;
    localparam logic [3:0]  c_srl    = 4'b0101;
    localparam logic [3:0]  c_sra    = 4'b1101;
`ifdef SHIFT_UNIT_ROT_EN
    localparam logic [3:0]  c_rol    = 4'b0011;
    localparam logic [3:0]  c_ror    = 4'b0111;
    localparam logic [SW:0] c_xlen_w = XLEN[SW:0];
`endif
    localparam logic [SW:0] c_step_w = STEP[SW:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [XLEN-1:0]   r_acc;
    logic [SW-1:0]     r_rem;
    logic [3:0]        r_op;
    logic [XLEN-1:0]   r_res;

    logic [SW-1:0]     w_shamt;
    logic              w_supported;
    logic              w_accept;
    logic [SW:0]       w_k;
    logic [XLEN-1:0]   w_acc_next;
    logic [SW-1:0]     w_rem_next;
    logic              w_unused_op2;

    assign w_shamt      = op2_i[SW-1:0];
    assign w_unused_op2 = ^op2_i[XLEN-1:SW];

    always_comb begin
        w_supported = 1'b0;
        case (funct_i)
            c_sll, c_srl, c_sra: w_supported = 1'b1;
`ifdef SHIFT_UNIT_ROT_EN
            c_rol, c_ror:        w_supported = 1'b1;
`endif
            default:             w_supported = 1'b0;
        endcase
    end

    // Ready is masked by reset so nothing is accepted while the unit is held.
    assign req_ready_o  = (r_state == S_IDLE) && !rst_i;
    assign w_accept     = req_valid_i && req_ready_o;
    assign resp_valid_o = (r_state == S_DONE);
    assign busy_o       = (r_state == S_SHIFT) || (r_state == S_DONE);
    assign res_o        = r_res;

    // One step of at most STEP positions; rem is never zero inside SHIFT.
    always_comb begin
        w_k        = ({1'b0, r_rem} < c_step_w) ? {1'b0, r_rem} : c_step_w;
        w_rem_next = r_rem - w_k[SW-1:0];
        w_acc_next = '0;
        case (r_op)
            c_sll:   w_acc_next = r_acc << w_k;
            c_srl:   w_acc_next = r_acc >> w_k;
            c_sra:   w_acc_next = $unsigned($signed(r_acc) >>> w_k);
`ifdef SHIFT_UNIT_ROT_EN
            c_rol:   w_acc_next = (r_acc << w_k) | (r_acc >> (c_xlen_w - w_k));
            c_ror:   w_acc_next = (r_acc >> w_k) | (r_acc << (c_xlen_w - w_k));
`endif
            default: w_acc_next = '0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if ((w_shamt == '0) || !w_supported) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (w_rem_next == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (resp_ready_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_rem   <= '0;
            r_op    <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc <= w_supported ? op1_i : '0;
                        r_rem <= w_shamt;
                        r_op  <= funct_i;
                        // Immediate completions publish their result now.
                        if ((w_shamt == '0) || !w_supported) begin
                            r_res <= w_supported ? op1_i : '0;
                        end
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_acc_next;
                    r_rem <= w_rem_next;
                    if (w_rem_next == '0) begin
                        r_res <= w_acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_shift_unit_mc.sv
// ============================================================================
// Module   : tb_shift_unit_mc
// Purpose  : Directed self-checking bench for shift_unit_mc (XLEN=32, STEP=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_unit_mc;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  funct;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] res;
    logic        busy;

    int checks;
    int fails;

    shift_unit_mc #(
        .XLEN (32),
        .STEP (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .funct_i      (funct),
        .op1_i        (op1),
        .op2_i        (op2),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .res_o        (res),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, measure latency, optionally hold the response, then take it.
    task automatic run_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input int hold);
        int n;
        logic [31:0] first_res;
        funct     = f;
        op1       = a;
        op2       = b;
        req_valid = 1'b1;
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        funct     = 4'(($urandom));
        op1       = $urandom;
        op2       = $urandom;
        n = 1;
        while (!resp_valid && n < 30) begin
            chk({tag, "_ready_low"}, {31'd0, req_ready}, 32'd0);
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_res"}, res, exp_res);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        first_res = res;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_res"}, res, first_res);
            chk({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
            chk({tag, "_hold_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        checks     = 0;
        fails      = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        funct      = 4'd0;
        op1        = '0;
        op2        = '0;
        tick();
        tick();
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_res", res, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

        run_op("sll5", 4'b0001, 32'h0000_0001, 32'hFFFF_FFE5, 32'h0000_0020, 3, 0);
        run_op("sra31", 4'b1101, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 9, 0);
        run_op("srl31", 4'b0101, 32'h8000_0000, 32'd31, 32'h0000_0001, 9, 0);
        run_op("srl0", 4'b0101, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1, 0);
        run_op("sra_pos", 4'b1101, 32'h7000_0000, 32'd6, 32'h01C0_0000, 3, 0);
        run_op("unsup", 4'b1111, 32'h1234_5678, 32'd7, 32'h0000_0000, 1, 0);
        run_op("bp_sll", 4'b0001, 32'h0000_00A5, 32'd8, 32'h0000_A500, 3, 10);
        run_op("after_bp", 4'b0101, 32'hF000_0000, 32'd4, 32'h0F00_0000, 2, 0);

        // Abort a long shift two cycles in.
        funct     = 4'b0001;
        op1       = 32'h0000_0001;
        op2       = 32'd31;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_res", res, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        run_op("post_abort", 4'b0001, 32'h0000_0001, 32'd31, 32'h8000_0000, 9, 0);

`ifdef SHIFT_UNIT_ROT_EN
        run_op("ror4", 4'b0111, 32'h0000_00F1, 32'd4, 32'h1000_000F, 2, 0);
        run_op("rol5", 4'b0011, 32'h8000_0001, 32'd5, 32'h0000_0030, 3, 0);
`else
        run_op("ror4", 4'b0111, 32'h0000_00F1, 32'd4, 32'h0000_0000, 1, 0);
        run_op("rol5", 4'b0011, 32'h8000_0001, 32'd5, 32'h0000_0000, 1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
